jtag_host_shifter: RTL and testbench

// - Host-side JTAG initiator that drives the target TAP (the IR, bypass, ID and boundary-scan registers).
// - Takes one command at a time: TAP reset, IR scan or DR scan of 1..MAX_LEN bits.
// - Walks the TAP from Run-Test/Idle to Shift, shifts TDI out LSB-first, captures TDO, and returns to Run-Test/Idle.
// - Returns the captured bits on a one-cycle response strobe. Used by the on-chip debug/test sequencer and by benches.

---
 rtl/jtag_host_shifter.sv | 200 ++++++++++++++++++++
 tb/tb_jtag_host_shifter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_host_shifter.sv
// jtag_host_shifter: host-side JTAG initiator for IR/DR scans and TAP resets.
// One tick is two tck cycles (L then H); TDO is captured as jtag_tck rises.
module jtag_host_shifter #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               tck,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic               rsp_err,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               jtag_tck,
  output logic               jtag_tms,
  output logic               jtag_tdi,
  input  logic               jtag_tdo
);

  typedef enum logic [2:0] {
    S_INIT_RST,
    S_IDLE,
    S_HDR,
    S_SHIFT,
    S_TAIL,
    S_REJ,
    S_RST_SEQ,
    S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic               ph_q, ph_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ir_q, ir_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic               tck_q, tck_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;

  logic [LEN_W-1:0]   cnt_nx;
  logic [LEN_W-1:0]   last_bit;
  logic [MAX_LEN-1:0] data_sh;
  logic               bad_cmd;
  logic               hdr_done;

  assign cnt_nx   = cnt_q + LEN_W'(1);
  assign last_bit = len_q - LEN_W'(1);
  assign data_sh  = data_q >> cnt_nx;
  assign hdr_done = ir_q ? (cnt_q == LEN_W'(3)) : (cnt_q == LEN_W'(2));
  assign bad_cmd  = (cmd_op == 2'b11) ||
                    ((cmd_op != 2'b00) &&
                     ((cmd_len == '0) || (cmd_len > LEN_W'(MAX_LEN))));

  // State and output registers; reset parks the TAP lines at TMS=1, TCK=0.
  always_ff @(posedge tck or posedge reset) begin
    if (reset) begin
      state_q     <= S_INIT_RST;
      ph_q        <= 1'b0;
      cnt_q       <= '0;
      len_q       <= '0;
      ir_q        <= 1'b0;
      data_q      <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      ir_q        <= ir_d;
      data_q      <= data_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
    end
  end

  // Command accept, tick phase sequencing, TMS/TDI generation, TDO capture.
  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    ir_d        = ir_q;
    data_d      = data_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          ph_d   = 1'b0;
          cnt_d  = '0;
          tck_d  = 1'b0;
          len_d  = cmd_len;
          data_d = cmd_data;
          ir_d   = (cmd_op == 2'b01);
          if (bad_cmd) begin
            state_d    = S_REJ;
            rsp_data_d = '0;
          end else if (cmd_op == 2'b00) begin
            state_d = S_RST_SEQ;
            tms_d   = 1'b1;
          end else begin
            state_d    = S_HDR;
            tms_d      = 1'b1;
            rsp_data_d = '0;
          end
        end
      end
      S_REJ: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
      end
      S_RESP: state_d = S_IDLE;
      default: begin
        if (!ph_q) begin
          ph_d  = 1'b1;
          tck_d = 1'b1;
          if (state_q == S_SHIFT)
            rsp_data_d = rsp_data_q | (MAX_LEN'(jtag_tdo) << cnt_q);
        end else begin
          ph_d  = 1'b0;
          tck_d = 1'b0;
          cnt_d = cnt_nx;
          unique case (state_q)
            S_INIT_RST, S_RST_SEQ: begin
              tms_d = (cnt_nx != LEN_W'(5));
              if (cnt_q == LEN_W'(5)) begin
                cnt_d       = '0;
                tms_d       = 1'b0;
                rsp_valid_d = (state_q == S_RST_SEQ);
                state_d     = (state_q == S_RST_SEQ) ? S_RESP : S_IDLE;
              end
            end
            S_HDR: begin
              if (hdr_done) begin
                state_d = S_SHIFT;
                cnt_d   = '0;
                tms_d   = (len_q == LEN_W'(1));
                tdi_d   = data_q[0];
              end else begin
                tms_d = ir_q && (cnt_q == '0);
              end
            end
            S_SHIFT: begin
              if (cnt_q == last_bit) begin
                state_d = S_TAIL;
                cnt_d   = '0;
                tms_d   = 1'b1;
                tdi_d   = 1'b0;
              end else begin
                tdi_d = data_sh[0];
                tms_d = (cnt_nx == last_bit);
              end
            end
            S_TAIL: begin
              tms_d = 1'b0;
              if (cnt_q != '0) begin
                state_d     = S_RESP;
                cnt_d       = '0;
                rsp_valid_d = 1'b1;
              end
            end
            default: state_d = S_INIT_RST;
          endcase
        end
      end
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign jtag_tck  = tck_q;
  assign jtag_tms  = tms_q;
  assign jtag_tdi  = tdi_q;

endmodule

// File: tb/tb_jtag_host_shifter.sv
// tb_jtag_host_shifter: bench with a behavioural TAP target and timing model.
// Directed literal cases first, then randomized commands and resets.
module tb_jtag_host_shifter;
  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;
  localparam int LIM     = 400;

  localparam int M_IDLE = 0;
  localparam int M_INIT = 1;
  localparam int M_SCAN = 2;
  localparam int M_TRST = 3;
  localparam int M_REJ  = 4;

  typedef enum int {
    TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
    SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR
  } tap_t;

  logic               tck = 1'b0;
  logic               reset = 1'b0;
  logic               cmd_valid = 1'b0;
  logic [1:0]         cmd_op = '0;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               cmd_ready, rsp_valid, rsp_err, busy;
  logic [MAX_LEN-1:0] rsp_data;
  logic               jtag_tck, jtag_tms, jtag_tdi;
  logic               jtag_tdo = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 tck = ~tck;

  jtag_host_shifter #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .tck(tck), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .busy(busy),
    .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi),
    .jtag_tdo(jtag_tdo)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic tap_t tap_next(input tap_t s, input logic tms);
    case (s)
      TLR:     return tms ? TLR   : RTI;
      RTI:     return tms ? SELDR : RTI;
      SELDR:   return tms ? SELIR : CAPDR;
      CAPDR:   return tms ? EX1DR : SHDR;
      SHDR:    return tms ? EX1DR : SHDR;
      EX1DR:   return tms ? UPDR  : PADR;
      PADR:    return tms ? EX2DR : PADR;
      EX2DR:   return tms ? UPDR  : SHDR;
      UPDR:    return tms ? SELDR : RTI;
      SELIR:   return tms ? TLR   : CAPIR;
      CAPIR:   return tms ? EX1IR : SHIR;
      SHIR:    return tms ? EX1IR : SHIR;
      EX1IR:   return tms ? UPIR  : PAIR;
      PAIR:    return tms ? EX2IR : PAIR;
      EX2IR:   return tms ? UPIR  : SHIR;
      UPIR:    return tms ? SELDR : RTI;
      default: return TLR;
    endcase
  endfunction

  // Target TAP model state
  tap_t        tap = TLR;
  logic [63:0] sreg = '0;
  logic [63:0] dr_cap = '0;
  logic [63:0] ir_cap = '0;
  logic        in_bits[$];
  logic        tms_log[$];
  int          last_upd = 0;
  int          upd_n = 0;
  logic [63:0] upd_bits = '0;
  bit          saw_tlr = 1'b0;
  bit          prev_jtck = 1'b0;

  // Expected-behaviour model state
  int          mode = M_INIT;
  int          t = -1;
  int          nticks = 0;
  int          exp_len = 0;
  bit          exp_ir = 1'b0;
  bit          exp_err = 1'b0;
  logic [63:0] exp_in = '0;
  logic [63:0] mask = '0;
  logic [31:0] rsp_model = '0;
  int          last_rv_t = -1;
  logic [31:0] last_rsp = '0;
  bit          last_err = 1'b0;
  int          rv_cnt = 0;
  bit          e_tck, e_rv, e_ready;

  function automatic logic [63:0] tms_bits();
    logic [63:0] r = '0;
    foreach (tms_log[i]) if (i < 64) r[i] = tms_log[i];
    return r;
  endfunction

  // Target TAP plus per-cycle comparison against the timing model
  always @(negedge tck) begin
    if (jtag_tck && !prev_jtck) begin
      tms_log.push_back(jtag_tms);
      if (tap == CAPDR || tap == CAPIR) begin
        sreg = (tap == CAPDR) ? dr_cap : ir_cap;
        in_bits.delete();
      end
      if (tap == SHDR || tap == SHIR) begin
        in_bits.push_back(jtag_tdi);
        sreg = {jtag_tdi, sreg[63:1]};
      end else begin
        chk("tdi_outside_shift", 64'(jtag_tdi), 64'd0);
      end
      tap = tap_next(tap, jtag_tms);
      if (tap == TLR) saw_tlr = 1'b1;
      if (tap == UPDR || tap == UPIR) begin
        last_upd = (tap == UPIR) ? 2 : 1;
        upd_n = in_bits.size();
        upd_bits = '0;
        foreach (in_bits[i]) if (i < 64) upd_bits[i] = in_bits[i];
      end
    end
    if (!jtag_tck && prev_jtck)
      jtag_tdo = (tap == SHDR || tap == SHIR) ? sreg[0] : 1'b0;
    prev_jtck = jtag_tck;

    if (reset) begin
      chk("reset_outs",
          64'({jtag_tck, jtag_tms, jtag_tdi, cmd_ready, busy,
               rsp_valid, rsp_err}),
          64'(7'b0100100));
      chk("reset_rsp_data", 64'(rsp_data), 64'd0);
      mode = M_INIT;
      t = -1;
      rsp_model = '0;
      tms_log.delete();
    end else begin
      if (mode != M_IDLE) t++;
      e_tck = 1'b0;
      e_rv = 1'b0;
      e_ready = 1'b0;
      case (mode)
        M_IDLE: e_ready = 1'b1;
        M_INIT: begin
          e_tck = (t < 12) && (t % 2 == 1);
          e_ready = (t >= 12);
        end
        M_SCAN, M_TRST: begin
          e_tck = (t < 2 * nticks) && (t % 2 == 1);
          e_rv = (t == 2 * nticks);
          e_ready = (t == 2 * nticks + 1);
        end
        M_REJ: begin
          e_rv = (t == 1);
          e_ready = (t == 2);
        end
        default: e_ready = 1'b0;
      endcase
      chk("cycle_outs", 64'({jtag_tck, rsp_valid, cmd_ready, busy}),
          64'({e_tck, e_rv, e_ready, !e_ready}));
      if (rsp_valid) begin
        rv_cnt++;
        last_rv_t = t;
        last_rsp = rsp_data;
        last_err = rsp_err;
      end
      if (e_rv) begin
        chk("rsp_err", 64'(rsp_err), 64'(exp_err));
        chk("rsp_data", 64'(rsp_data), 64'(rsp_model));
        if (mode == M_SCAN) begin
          chk("scan_end_rti", 64'(tap == RTI), 64'd1);
          chk("scan_kind", 64'(last_upd), 64'(exp_ir ? 2 : 1));
          chk("scan_len", 64'(upd_n), 64'(exp_len));
          chk("scan_tdi_bits", upd_bits, exp_in);
        end else if (mode == M_TRST) begin
          chk("trst_path", 64'({saw_tlr, tap == RTI}), 64'(2'b11));
        end
      end
      if (mode == M_IDLE) chk("rsp_hold", 64'(rsp_data), 64'(rsp_model));
      if (e_ready && mode != M_IDLE) begin
        if (mode == M_INIT) chk("init_end_rti", 64'(tap == RTI), 64'd1);
        mode = M_IDLE;
      end
      if (cmd_valid && cmd_ready) begin
        t = -1;
        last_upd = 0;
        saw_tlr = 1'b0;
        tms_log.delete();
        exp_len = int'(cmd_len);
        exp_ir = (cmd_op == 2'b01);
        exp_err = 1'b0;
        if (cmd_op == 2'b11 ||
            (cmd_op != 2'b00 && (exp_len == 0 || exp_len > MAX_LEN))) begin
          mode = M_REJ;
          exp_err = 1'b1;
          rsp_model = '0;
        end else if (cmd_op == 2'b00) begin
          mode = M_TRST;
          nticks = 6;
        end else begin
          mode = M_SCAN;
          nticks = (exp_ir ? 4 : 3) + exp_len + 2;
          mask = (64'd1 << exp_len) - 64'd1;
          exp_in = 64'(cmd_data) & mask;
          rsp_model = 32'((exp_ir ? ir_cap : dr_cap) & mask);
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [LEN_W-1:0] len,
                      input logic [31:0] data);
    int n = 0;
    while (!cmd_ready && n < LIM) begin
      @(posedge tck); #1;
      n++;
    end
    chk("send_wait_timeout", 64'(n >= LIM), 64'd0);
    @(posedge tck); #1;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_len = len;
    cmd_data = data;
    @(posedge tck); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!cmd_ready && n < LIM) begin
      @(posedge tck); #1;
      n++;
    end
    chk("idle_wait_timeout", 64'(n >= LIM), 64'd0);
  endtask

  task automatic pulse_reset();
    int n = 0;
    while (jtag_tck && n < 10) begin
      @(posedge tck); #1;
      n++;
    end
    reset = 1'b1;
    #1;
    chk("reset_immediate",
        64'({jtag_tck, jtag_tms, jtag_tdi, cmd_ready, busy, rsp_valid}),
        64'(6'b010010));
    repeat (3) @(posedge tck);
    #1 reset = 1'b0;
  endtask

  initial begin
    int n, k1, k2, rv0, r, op, len, d;
    #2 reset = 1'b1;
    repeat (3) @(posedge tck);
    #1 reset = 1'b0;

    n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge tck); #1;
      n++;
    end
    chk("init_ready_cycle", 64'(n), 64'd12);
    chk("init_tms_count", 64'(tms_log.size()), 64'd6);
    chk("init_tms_seq", tms_bits(), 64'h1F);

    dr_cap = 64'hDEAD_BEEF_1234_5679;
    send(2'b10, 6'd32, 32'hCAFE_F00D);
    wait_idle();
    chk("idcode_data", 64'(last_rsp), 64'h1234_5679);
    chk("idcode_latency", 64'(last_rv_t), 64'd74);
    chk("idcode_err", 64'(last_err), 64'd0);

    ir_cap = 64'h5;
    send(2'b01, 6'd4, 32'hA);
    wait_idle();
    chk("ir_tms_count", 64'(tms_log.size()), 64'd10);
    chk("ir_tms_seq", tms_bits(), 64'h183);
    chk("ir_tdi_bits", upd_bits, 64'hA);
    chk("ir_rsp", 64'(last_rsp), 64'h5);
    chk("ir_latency", 64'(last_rv_t), 64'd20);

    for (int i = 0; i < 3; i++) begin
      case (i)
        0: send(2'b10, 6'd0, 32'h1);
        1: send(2'b01, 6'd33, 32'h3);
        default: send(2'b11, 6'd8, 32'hFF);
      endcase
      wait_idle();
      chk("rej_latency", 64'(last_rv_t), 64'd1);
      chk("rej_err", 64'(last_err), 64'd1);
      chk("rej_data", 64'(last_rsp), 64'd0);
      chk("rej_no_jtck", 64'(tms_log.size()), 64'd0);
    end

    send(2'b00, 6'd0, 32'h0);
    wait_idle();
    chk("trst_latency", 64'(last_rv_t), 64'd12);

    dr_cap = {$urandom, $urandom};
    send(2'b10, 6'd16, $urandom);
    n = 0;
    while (!(tap == SHDR && in_bits.size() == 7 && !jtag_tck) && n < LIM) begin
      @(posedge tck); #1;
      n++;
    end
    chk("midshift_reach", 64'(n >= LIM), 64'd0);
    rv0 = rv_cnt;
    pulse_reset();
    wait_idle();
    chk("midshift_no_rsp", 64'(rv_cnt), 64'(rv0));
    chk("midshift_init_tms", tms_bits(), 64'h1F);

    dr_cap = 64'h1;
    @(posedge tck); #1;
    cmd_valid = 1'b1;
    cmd_op = 2'b10;
    cmd_len = 6'd1;
    cmd_data = 32'h1;
    n = 0;
    do begin
      @(negedge tck);
      n++;
    end while (!cmd_ready && n < LIM);
    @(posedge tck); #1;
    k1 = -1;
    k2 = -1;
    n = 0;
    while (k2 < 0 && n < LIM) begin
      @(negedge tck);
      n++;
      if (rsp_valid) begin
        k1 = n;
        chk("b2b_first_rsp", 64'(rsp_data), 64'd1);
      end
      if (cmd_ready) k2 = n;
    end
    chk("b2b_gap", 64'(k2 - k1), 64'd1);
    @(posedge tck); #1;
    cmd_valid = 1'b0;
    wait_idle();
    chk("b2b_second_rsp", 64'(last_rsp), 64'd1);

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 99);
      op = (r < 10) ? 0 : (r < 40) ? 1 : (r < 85) ? 2 : 3;
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63)
                                         : $urandom_range(1, 32);
      dr_cap = {$urandom, $urandom};
      ir_cap = {$urandom, $urandom};
      send(2'(op), 6'(len), $urandom);
      if ($urandom_range(0, 7) == 0) begin
        d = $urandom_range(0, 40);
        repeat (d) @(posedge tck);
        #1;
        pulse_reset();
      end
      wait_idle();
    end

    repeat (4) @(posedge tck);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
